// File: rtl/sram_stage_sequencer.sv
// Hands SRAM ownership to a chain of processing stages in index order,
// with a per-stage inactivity watchdog and an optional held final owner.
module sram_stage_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int HOLD_LAST      = 1
) (
    input  logic                         CLOCK_50_I,
    input  logic                         Resetn,
    input  logic                         go_i,
    input  logic                         abort_i,
    input  logic [NUM_STAGES-1:0]        stage_en_i,
    input  logic [NUM_STAGES-1:0]        stage_done_i,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr_i,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata_i,
    input  logic [NUM_STAGES-1:0]        stage_we_n_i,
    output logic [NUM_STAGES-1:0]        stage_start_o,
    output logic [ADDR_W-1:0]            SRAM_address,
    output logic [DATA_W-1:0]            SRAM_write_data,
    output logic                         SRAM_we_n,
    output logic [2:0]                   active_stage_o,
    output logic                         busy_o,
    output logic                         seq_done_o,
    output logic                         error_o
);

    localparam bit WD_ON = (TIMEOUT_CYCLES > 0);
    localparam int WD_W  = WD_ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT =
        WD_W'(WD_ON ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_HOLD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [2:0]              stage_q;
    logic [NUM_STAGES-1:0]   mask_q;
    logic [WD_W-1:0]         wdog_q;
    logic                    error_q;

    logic                    first_found;
    logic [2:0]              first_idx;
    logic                    next_found;
    logic [2:0]              next_idx;
    logic                    sel_done;
    logic                    sel_we_n;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic [NUM_STAGES-1:0]   sel_onehot;
    logic                    wd_expired;
    logic                    owned;
    logic                    accept_go;

    // Descending scans leave the lowest matching index in the result.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_en_i[i]) begin
                first_found = 1'b1;
                first_idx   = 3'(i);
            end
            if (mask_q[i] && (3'(i) > stage_q)) begin
                next_found = 1'b1;
                next_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        sel_done   = 1'b0;
        sel_we_n   = 1'b1;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_q == 3'(i)) begin
                sel_done      = stage_done_i[i];
                sel_we_n      = stage_we_n_i[i];
                sel_addr      = stage_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata     = stage_wdata_i[i*DATA_W +: DATA_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign wd_expired = WD_ON && (wdog_q == WD_LIMIT);
    assign accept_go  = go_i && !abort_i &&
                        ((state == S_IDLE) || (state == S_ERROR));

    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_ERROR: begin
                if (go_i) begin
                    state_nx = first_found ? S_START : S_DONE;
                end
            end
            S_START: begin
                state_nx = ((HOLD_LAST != 0) && !next_found) ? S_HOLD : S_RUN;
            end
            S_RUN: begin
                if (sel_done) begin
                    state_nx = next_found ? S_START : S_DONE;
                end else if (wd_expired) begin
                    state_nx = S_ERROR;
                end
            end
            S_HOLD:  state_nx = S_HOLD;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort_i) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn) begin
            stage_q <= '0;
            mask_q  <= '0;
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else if (!abort_i) begin
            if (accept_go) begin
                mask_q  <= stage_en_i;
                error_q <= 1'b0;
                if (first_found) begin
                    stage_q <= first_idx;
                end
            end
            if ((state == S_RUN) && sel_done && next_found) begin
                stage_q <= next_idx;
            end
            if ((state == S_RUN) && !sel_done && wd_expired) begin
                error_q <= 1'b1;
            end
            // Any write by the owner counts as proof of life.
            if ((state_nx == S_START) || (state == S_START) || !sel_we_n) begin
                wdog_q <= '0;
            end else if (state == S_RUN) begin
                wdog_q <= wdog_q + 1'b1;
            end
        end
    end

    always_comb begin
        owned           = (state == S_START) || (state == S_RUN) ||
                          (state == S_HOLD);
        busy_o          = owned;
        seq_done_o      = (state == S_DONE);
        stage_start_o   = (state == S_START) ? sel_onehot : '0;
        SRAM_address    = owned ? sel_addr : '0;
        SRAM_write_data = owned ? sel_wdata : '0;
        SRAM_we_n       = owned ? sel_we_n : 1'b1;
        active_stage_o  = stage_q;
        error_o         = error_q;
    end

endmodule
